// File: rtl/minimig_sram_sequencer_pkg.sv
// rtl/minimig_sram_sequencer_pkg.sv - shared types and helpers for the SRAM sequencer
//
// Package minimig_ram_pkg: FSM state encoding, bus phase decode, default constants.

package minimig_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          TIMEOUT_CYC_DEFAULT = 24;
    localparam logic [15:0] ABORT_DATA_DEFAULT  = 16'hFFFF;

    // Q1: strobe sampling phase of the bus cycle
    function automatic logic is_q1(input logic c1, input logic c3);
        return c1 & ~c3;
    endfunction

    // Q0: end of bus cycle, used to release the sequencer back to idle
    function automatic logic is_q0(input logic c1, input logic c3);
        return ~c1 & ~c3;
    endfunction

endpackage

// File: rtl/minimig_sram_sequencer_if.sv
// rtl/minimig_sram_sequencer_if.sv - req/ack port toward the memory controller
//
// master: sequencer side (drives request, address, data, byte selects)
// slave:  controller side (drives one-cycle ack and read data)

interface minimig_sram_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_bs;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_bs,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_bs,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/minimig_sram_sequencer_wbuf.sv
// rtl/minimig_sram_sequencer_wbuf.sv - one-entry posted write buffer
//
// Module minimig_ram_wbuf.
// Ports: clk, reset (sync, active-high); push with push_addr/push_data/push_bs
// captures an entry; pop empties it; valid/addr/data/bs present the entry.

module minimig_ram_wbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [21:0] push_addr,
    input  logic [15:0] push_data,
    input  logic [1:0]  push_bs,
    input  logic        pop,
    output logic        valid,
    output logic [21:0] addr,
    output logic [15:0] data,
    output logic [1:0]  bs
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            bs    <= '0;
        end else if (push) begin
            valid <= 1'b1;
            addr  <= push_addr;
            data  <= push_data;
            bs    <= push_bs;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/minimig_sram_sequencer.sv
// rtl/minimig_sram_sequencer.sv - chipset SRAM strobes to req/ack memory transactions
//
// Samples _oe/_we/_bhe/_ble/address/data on Q1 and issues one request per bus cycle.
// Ports: clk, reset (sync, active-high); c1/c3 bus phase; bridge strobes, address, data;
// ramdata read-back; busy/timeout/overrun status; mem (controller port, master modport).
// Optional macro MINIMIG_SRAM_WRITE_POST_EN: one-entry posted write buffer.

module minimig_sram_sequencer
    import minimig_ram_pkg::*;
#(
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter logic [15:0] ABORT_DATA  = ABORT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c1,
    input  logic        c3,
    input  logic        _oe,
    input  logic        _we,
    input  logic        _bhe,
    input  logic        _ble,
    input  logic [21:0] address,
    input  logic [15:0] data,
    output logic [15:0] ramdata,
    output logic        busy,
    output logic        timeout,
    output logic        overrun,
    minimig_sram_sequencer_if.master mem
);
    localparam int             CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          req_we;
    logic [21:0]   req_addr;
    logic [15:0]   req_wdata;
    logic [1:0]    req_bs;

    logic q0, q1, start, start_wr;
    logic take_new, take_buf, finish_ack, finish_to, post, drop;

    logic        wb_valid;
    logic [21:0] wb_addr;
    logic [15:0] wb_data;
    logic [1:0]  wb_bs;

    assign q1       = is_q1(c1, c3);
    assign q0       = is_q0(c1, c3);
    assign start    = q1 & (~_oe | ~_we);
    assign start_wr = ~_we;            // both strobes low is treated as a write

`ifdef MINIMIG_SRAM_WRITE_POST_EN
    minimig_ram_wbuf u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (post),
        .push_addr (address),
        .push_data (data),
        .push_bs   ({~_bhe, ~_ble}),
        .pop       (take_buf),
        .valid     (wb_valid),
        .addr      (wb_addr),
        .data      (wb_data),
        .bs        (wb_bs)
    );
`else
    assign wb_valid = 1'b0;
    assign wb_addr  = '0;
    assign wb_data  = '0;
    assign wb_bs    = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_new   = 1'b0;
        take_buf   = 1'b0;
        finish_ack = 1'b0;
        finish_to  = 1'b0;
        post       = 1'b0;
        drop       = 1'b0;
        case (state)
            ST_IDLE: begin
                // a posted write drains ahead of any new start, without waiting for Q1
                if (wb_valid) begin
                    take_buf  = 1'b1;
                    state_nxt = ST_REQ;
                end else if (start) begin
                    take_new  = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // ack has priority over an expiring counter
                if (mem.mem_ack) begin
                    finish_ack = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    finish_to = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (q0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // starts that cannot be issued on this edge
        if (start && !take_new) begin
`ifdef MINIMIG_SRAM_WRITE_POST_EN
            if (start_wr) begin
                if (wb_valid) drop = 1'b1;
                else          post = 1'b1;
            end else if (wb_valid) begin
                drop = 1'b1;
            end
`else
            drop = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_bs    <= '0;
            ramdata   <= 16'h0000;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            timeout <= finish_to;
            overrun <= drop;
            if (take_new) begin
                req_we    <= start_wr;
                req_addr  <= address;
                req_wdata <= data;
                req_bs    <= start_wr ? {~_bhe, ~_ble} : 2'b11;
            end else if (take_buf) begin
                req_we    <= 1'b1;
                req_addr  <= wb_addr;
                req_wdata <= wb_data;
                req_bs    <= wb_bs;
            end
            if (take_new || take_buf)
                cnt <= '0;
            else if (state == ST_REQ && cnt != CNT_LAST)
                cnt <= cnt + 1'b1;
            if (finish_ack && !req_we)
                ramdata <= mem.mem_rdata;
            else if (finish_to && !req_we)
                ramdata <= ABORT_DATA;
        end
    end

    assign busy          = (state != ST_IDLE);
    assign mem.mem_req   = (state == ST_REQ);
    assign mem.mem_we    = req_we;
    assign mem.mem_addr  = req_addr;
    assign mem.mem_wdata = req_wdata;
    assign mem.mem_bs    = req_bs;

endmodule

// File: tb/tb_minimig_sram_sequencer.sv
// tb/tb_minimig_sram_sequencer.sv - self-checking bench for minimig_sram_sequencer

module tb_minimig_sram_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        c1, c3;
    logic        _oe, _we, _bhe, _ble;
    logic [21:0] address;
    logic [15:0] data;
    logic [15:0] ramdata;
    logic        busy, timeout, overrun;

    minimig_sram_sequencer_if mem_bus ();

    minimig_sram_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .c1      (c1),
        .c3      (c3),
        ._oe     (_oe),
        ._we     (_we),
        ._bhe    (_bhe),
        ._ble    (_ble),
        .address (address),
        .data    (data),
        .ramdata (ramdata),
        .busy    (busy),
        .timeout (timeout),
        .overrun (overrun),
        .mem     (mem_bus.master)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        _oe, _we, _bhe, _ble;
        logic [21:0] addr;
        logic [15:0] wdata;
        int          ack_dly;
        logic [15:0] rdata;
        logic [1:0]  exp_bs;
        logic        exp_we;
        logic [15:0] exp_ram;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        c1 = 1'b0; c3 = 1'b1;
        _oe = 1'b1; _we = 1'b1; _bhe = 1'b1; _ble = 1'b1;
    endtask

    task automatic drive_q1(input logic oe, input logic we, input logic bhe, input logic ble,
                            input logic [21:0] a, input logic [15:0] d);
        c1 = 1'b1; c3 = 1'b0;
        _oe = oe; _we = we; _bhe = bhe; _ble = ble;
        address = a; data = d;
    endtask

    task automatic pass_q0();
        c1 = 1'b0; c3 = 1'b0;
        tick();
        c3 = 1'b1;
    endtask

    task automatic ack_now(input logic [15:0] rd);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rd;
        tick();
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        int n;
        //        _oe   _we   _bhe  _ble  addr        wdata     dly rdata     bs     we    ramdata
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 22'h00_1234, 16'h0000, 3, 16'hBEEF, 2'b11, 1'b0, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 22'h02_0000, 16'hA55A, 2, 16'h1111, 2'b10, 1'b1, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 22'h3F_FFFF, 16'h1234, 1, 16'h2222, 2'b01, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 22'h15_5555, 16'hC3C3, 4, 16'h3333, 2'b11, 1'b1, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 22'h2A_AAAA, 16'h0F0F, 1, 16'h5A5A, 2'b11, 1'b0, 16'h5A5A};

        reset = 1'b1;
        bus_idle();
        address = '0; data = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_req",     mem_bus.mem_req,   0);
        chk("rst_we",      mem_bus.mem_we,    0);
        chk("rst_addr",    mem_bus.mem_addr,  0);
        chk("rst_wdata",   mem_bus.mem_wdata, 0);
        chk("rst_bs",      mem_bus.mem_bs,    0);
        chk("rst_ramdata", ramdata,           16'h0000);
        chk("rst_busy",    busy,              0);
        chk("rst_timeout", timeout,           0);
        chk("rst_overrun", overrun,           0);

        // table-driven single accesses
        for (int i = 0; i < 5; i++) begin
            drive_q1(vecs[i]._oe, vecs[i]._we, vecs[i]._bhe, vecs[i]._ble, vecs[i].addr, vecs[i].wdata);
            tick();
            bus_idle();
            chk($sformatf("v%0d_req", i),   mem_bus.mem_req,  1);
            chk($sformatf("v%0d_bs", i),    mem_bus.mem_bs,   vecs[i].exp_bs);
            chk($sformatf("v%0d_we", i),    mem_bus.mem_we,   vecs[i].exp_we);
            chk($sformatf("v%0d_addr", i),  mem_bus.mem_addr, vecs[i].addr);
            if (vecs[i].exp_we)
                chk($sformatf("v%0d_wdata", i), mem_bus.mem_wdata, vecs[i].wdata);
            repeat (vecs[i].ack_dly - 1) tick();
            chk($sformatf("v%0d_req_hold", i), mem_bus.mem_req, 1);
            ack_now(vecs[i].rdata);
            chk($sformatf("v%0d_req_drop", i), mem_bus.mem_req, 0);
            chk($sformatf("v%0d_ramdata", i),  ramdata, vecs[i].exp_ram);
            chk($sformatf("v%0d_busy_done", i), busy, 1);
            pass_q0();
            chk($sformatf("v%0d_idle", i), busy, 0);
            repeat (2) tick();
            chk($sformatf("v%0d_ram_hold", i), ramdata, vecs[i].exp_ram);
        end

        // read with no ack: abort after TIMEOUT_CYC clocks
        drive_q1(1'b0, 1'b1, 1'b1, 1'b1, 22'h00_0042, 16'h0000);
        tick();
        bus_idle();
        chk("to_req", mem_bus.mem_req, 1);
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n, 24);
        chk("to_ramdata", ramdata, 16'hFFFF);
        chk("to_req_drop", mem_bus.mem_req, 0);
        chk("to_busy", busy, 1);
        tick();
        chk("to_pulse", timeout, 0);
        chk("to_wait_q0", busy, 1);
        pass_q0();
        chk("to_idle", busy, 0);

        // ack in the same cycle the counter expires
        drive_q1(1'b0, 1'b1, 1'b1, 1'b1, 22'h00_0043, 16'h0000);
        tick();
        bus_idle();
        repeat (23) tick();
        chk("race_req", mem_bus.mem_req, 1);
        ack_now(16'h1357);
        chk("race_no_to", timeout, 0);
        chk("race_ramdata", ramdata, 16'h1357);
        tick();
        chk("race_no_to2", timeout, 0);
        pass_q0();
        chk("race_idle", busy, 0);

        // stray ack while idle
        ack_now(16'hDEAD);
        chk("stray_busy", busy, 0);
        chk("stray_req", mem_bus.mem_req, 0);
        chk("stray_ram", ramdata, 16'h1357);

        // second write at the next Q1 while the first is in REQ
        drive_q1(1'b1, 1'b0, 1'b0, 1'b0, 22'h00_0100, 16'h1111);
        tick();
        chk("ovr_req1", mem_bus.mem_req, 1);
        drive_q1(1'b1, 1'b0, 1'b0, 1'b0, 22'h00_0200, 16'h2222);
        tick();
        bus_idle();
        chk("ovr_addr1", mem_bus.mem_addr, 22'h00_0100);
`ifdef MINIMIG_SRAM_WRITE_POST_EN
        chk("ovr_none", overrun, 0);
        tick();
        ack_now(16'h0000);
        chk("post_req_drop", mem_bus.mem_req, 0);
        pass_q0();
        chk("post_idle", busy, 0);
        tick();
        chk("post_req2", mem_bus.mem_req, 1);
        chk("post_addr2", mem_bus.mem_addr, 22'h00_0200);
        chk("post_wdata2", mem_bus.mem_wdata, 16'h2222);
        chk("post_we2", mem_bus.mem_we, 1);
        ack_now(16'h0000);
        pass_q0();
        chk("post_idle2", busy, 0);
`else
        chk("ovr_pulse", overrun, 1);
        tick();
        chk("ovr_pulse_end", overrun, 0);
        ack_now(16'h0000);
        chk("ovr_req_drop", mem_bus.mem_req, 0);
        pass_q0();
        chk("ovr_idle", busy, 0);
        repeat (2) tick();
        chk("ovr_single_busy", busy, 0);
        chk("ovr_single_req", mem_bus.mem_req, 0);
`endif

        // reset while in REQ, then a late ack
        drive_q1(1'b0, 1'b1, 1'b1, 1'b1, 22'h00_0077, 16'h0000);
        tick();
        bus_idle();
        chk("rreq_req", mem_bus.mem_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rreq_req_drop", mem_bus.mem_req, 0);
        chk("rreq_busy", busy, 0);
        chk("rreq_ram", ramdata, 16'h0000);
        ack_now(16'hCAFE);
        chk("rreq_ack_ign_ram", ramdata, 16'h0000);
        chk("rreq_ack_ign_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
